// File: rtl/apb_io_scheduler.sv
// Scheduler between the APB IO conduit and up to 4 client cores: decodes host
// commands into client write pulses and round-robin captures client responses.
module apb_io_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int PAYLOAD_W   = 24
) (
    input  logic                             clock_clk,
    input  logic                             reset_n,
    input  logic [31:0]                      io_data_out,
    input  logic                             io_strobe,
    output logic [31:0]                      io_data_in,
    output logic [NUM_CLIENTS-1:0]           cl_wr_valid,
    output logic [PAYLOAD_W-1:0]             cl_wr_data,
    input  logic [NUM_CLIENTS-1:0]           cl_rd_valid,
    input  logic [NUM_CLIENTS*PAYLOAD_W-1:0] cl_rd_data,
    output logic [NUM_CLIENTS-1:0]           cl_rd_ready,
    output logic [7:0]                       err_count
);

    localparam int         GW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [4:0] NC5 = 5'(NUM_CLIENTS);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                  state_q, state_d;
    logic                    strobe_q;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [31:0]             io_data_in_q, io_data_in_d;
    logic [NUM_CLIENTS-1:0]  cl_wr_valid_q, cl_wr_valid_d;
    logic [PAYLOAD_W-1:0]    cl_wr_data_q, cl_wr_data_d;
    logic [7:0]              err_count_q, err_count_d;

    logic                    cmd_edge;
    logic [3:0]              cmd_id;
    logic                    cmd_client;
    logic                    cmd_pop;
    logic                    cmd_bad;
    logic                    grant_found;
    logic [GW-1:0]           grant_idx;
    logic                    capture;
    logic [PAYLOAD_W-1:0]    grant_data;
    logic                    unused_ok;

    assign unused_ok  = ^io_data_out[27:24];

    assign cmd_edge   = io_strobe & ~strobe_q;
    assign cmd_id     = io_data_out[31:28];
    assign cmd_client = cmd_edge && ({1'b0, cmd_id} < NC5);
    assign cmd_pop    = cmd_edge && (cmd_id == 4'hF);
    assign cmd_bad    = cmd_edge && !cmd_client && !cmd_pop;

    // Round-robin search starting just after the previous grant, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            if (!grant_found && cl_rd_valid[(int'(last_grant_q) + k) % NUM_CLIENTS]) begin
                grant_found = 1'b1;
                grant_idx   = GW'((int'(last_grant_q) + k) % NUM_CLIENTS);
            end
        end
    end

    assign capture    = (state_q == ST_EMPTY) && grant_found;
    assign grant_data = cl_rd_data[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];

    // Ready is masked during reset: no capture happens then, so no client may
    // believe its response was taken.
    always_comb begin
        cl_rd_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cl_rd_ready[i] = capture && reset_n && (grant_idx == GW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        io_data_in_d = io_data_in_q;
        if (capture) begin
            state_d      = ST_FULL;
            last_grant_d = grant_idx;
            io_data_in_d = {1'b1, 3'b000, 4'(grant_idx), grant_data};
        end else if ((state_q == ST_FULL) && cmd_pop) begin
            state_d      = ST_EMPTY;
            io_data_in_d = {1'b0, io_data_in_q[30:0]};
        end
    end

    always_comb begin
        cl_wr_valid_d = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cl_wr_valid_d[i] = cmd_client && (cmd_id == 4'(i));
        end
        cl_wr_data_d = cmd_client ? io_data_out[PAYLOAD_W-1:0] : cl_wr_data_q;
        err_count_d  = (cmd_bad && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clock_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_EMPTY;
            strobe_q      <= 1'b0;
            last_grant_q  <= GW'(NUM_CLIENTS - 1);
            io_data_in_q  <= '0;
            cl_wr_valid_q <= '0;
            cl_wr_data_q  <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            strobe_q      <= io_strobe;
            last_grant_q  <= last_grant_d;
            io_data_in_q  <= io_data_in_d;
            cl_wr_valid_q <= cl_wr_valid_d;
            cl_wr_data_q  <= cl_wr_data_d;
            err_count_q   <= err_count_d;
        end
    end

    assign io_data_in  = io_data_in_q;
    assign cl_wr_valid = cl_wr_valid_q;
    assign cl_wr_data  = cl_wr_data_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_io_scheduler.sv
// Directed plus randomized bench for apb_io_scheduler against a behavioural
// model of the command decode, response holding and round-robin rules.
module tb_apb_io_scheduler;

    logic        clock_clk;
    logic        reset_n;
    logic [31:0] io_data_out;
    logic        io_strobe;
    logic [31:0] io_data_in;
    logic [3:0]  cl_wr_valid;
    logic [23:0] cl_wr_data;
    logic [3:0]  cl_rd_valid;
    logic [95:0] cl_rd_data;
    logic [3:0]  cl_rd_ready;
    logic [7:0]  err_count;

    apb_io_scheduler #(.NUM_CLIENTS(4), .PAYLOAD_W(24)) dut (
        .clock_clk   (clock_clk),
        .reset_n     (reset_n),
        .io_data_out (io_data_out),
        .io_strobe   (io_strobe),
        .io_data_in  (io_data_in),
        .cl_wr_valid (cl_wr_valid),
        .cl_wr_data  (cl_wr_data),
        .cl_rd_valid (cl_rd_valid),
        .cl_rd_data  (cl_rd_data),
        .cl_rd_ready (cl_rd_ready),
        .err_count   (err_count)
    );

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_full;
    logic [31:0] m_resp;
    int          m_last;
    int          m_err;
    logic [3:0]  m_wrv;
    logic [23:0] m_wrd;
    bit          m_strobe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_resp = '0; m_last = 3; m_err = 0;
        m_wrv = '0; m_wrd = '0; m_strobe = 0;
    endtask

    // One clock with the currently driven inputs: checks ready before the edge,
    // advances the model, then checks registered outputs after the edge.
    task automatic cycle();
        int         g;
        logic [3:0] exp_rdy;
        bit         edge_seen;
        logic [3:0] id;
        #1;
        g = -1;
        if (!m_full) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && cl_rd_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'h0;
        chk("rd_ready", 32'(cl_rd_ready), 32'(exp_rdy));
        edge_seen = io_strobe && !m_strobe;
        id = io_data_out[31:28];
        m_wrv = (edge_seen && id < 4) ? 4'(1 << id) : 4'h0;
        if (edge_seen && id < 4) m_wrd = io_data_out[23:0];
        if (edge_seen && id >= 4 && id != 4'hF && m_err < 255) m_err++;
        if (g >= 0) begin
            m_resp = {1'b1, 3'b000, 4'(g), cl_rd_data[g*24 +: 24]};
            m_full = 1;
            m_last = g;
        end else if (m_full && edge_seen && id == 4'hF) begin
            m_full = 0;
            m_resp[31] = 1'b0;
        end
        m_strobe = io_strobe;
        @(posedge clock_clk);
        #1;
        chk("io_data_in", io_data_in, m_resp);
        chk("wr_valid", 32'(cl_wr_valid), 32'(m_wrv));
        chk("wr_data", 32'(cl_wr_data), 32'(m_wrd));
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic host_write(input logic [31:0] w);
        io_data_out = w;
        io_strobe   = 1'b1;
        cycle();
    endtask

    task automatic host_read();
        io_strobe = 1'b0;
        cycle();
    endtask

    task automatic cmd(input logic [31:0] w);
        host_write(w);
        host_read();
    endtask

    task automatic do_reset();
        io_strobe = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("rst_data_in", io_data_in, 32'h0);
        chk("rst_wr_valid", 32'(cl_wr_valid), 32'h0);
        chk("rst_wr_data", 32'(cl_wr_data), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_ready", 32'(cl_rd_ready), 32'h0);
        model_reset();
        @(negedge clock_clk);
        @(negedge clock_clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] saved;
    int          saved_err;
    logic [3:0]  grants[$];
    logic [3:0]  rid;

    initial begin
        reset_n     = 1'b0;
        io_data_out = '0;
        io_strobe   = 1'b0;
        cl_rd_valid = '0;
        cl_rd_data  = '0;
        model_reset();
        do_reset();

        // Single client write
        host_write(32'h2000_0ABC);
        chk("first_pulse", 32'(cl_wr_valid), 32'h4);
        chk("first_data", 32'(cl_wr_data), 32'h000ABC);
        host_read();
        chk("pulse_one_cycle", 32'(cl_wr_valid), 32'h0);

        // Back-to-back writes without an intervening read
        host_write(32'h1000_0011);
        host_write(32'h3000_0022);
        chk("no_second_pulse", 32'(cl_wr_valid), 32'h0);
        chk("first_write_kept", 32'(cl_wr_data), 32'h000011);
        host_read();

        // Bad ids and saturation
        cmd(32'h7000_0000);
        chk("err_one", 32'(err_count), 32'h1);
        repeat (300) cmd({4'h4 + 4'($urandom_range(0, 10)), 28'($urandom)});
        chk("err_saturate", 32'(err_count), 32'd255);

        // Clients 0 and 2 contending from reset
        do_reset();
        cl_rd_data  = {$urandom, $urandom, $urandom};
        cl_rd_valid = 4'b0101;
        cycle();
        chk("cap_client0", io_data_in, {8'h80, cl_rd_data[23:0]});
        cmd(32'hF000_0000);
        chk("cap_client2_id", 32'(io_data_in[27:24]), 32'h2);
        chk("cap_client2_full", 32'(io_data_in[31]), 32'h1);

        // Held response while another client waits
        cl_rd_valid = 4'b0010;
        saved = io_data_in;
        repeat (100) cycle();
        chk("full_hold", io_data_in, saved);

        // POP while empty is a harmless no-op
        cl_rd_valid = 4'b0000;
        cmd(32'hF000_0000);
        saved_err = int'(err_count);
        saved     = io_data_in;
        cmd(32'hF123_4567);
        chk("pop_empty_err", 32'(err_count), 32'(saved_err));
        chk("pop_empty_data", io_data_in, saved);

        // Fair rotation with all clients requesting
        cl_rd_valid = 4'hF;
        do_reset();
        cycle();
        grants.push_back(io_data_in[27:24]);
        repeat (7) begin
            cmd(32'hF000_0000);
            grants.push_back(io_data_in[27:24]);
        end
        for (int i = 0; i < 8; i++) chk("rr_order", 32'(grants[i]), 32'(i % 4));

        // Reset while FULL and during a write pulse
        host_write(32'h1000_0055);
        chk("pre_rst_pulse", 32'(cl_wr_valid), 32'h2);
        do_reset();
        cycle();
        chk("post_rst_prio", 32'(io_data_in[27:24]), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cl_rd_valid = 4'($urandom);
            cl_rd_data  = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                io_strobe = ~io_strobe;
                if (io_strobe) begin
                    case ($urandom_range(0, 7))
                        0, 1, 2, 3: rid = 4'($urandom_range(0, 3));
                        4:          rid = 4'h7;
                        5, 6:       rid = 4'hF;
                        default:    rid = 4'($urandom);
                    endcase
                    io_data_out = {rid, 4'($urandom), 24'($urandom)};
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_io_scheduler.md
# apb_io_scheduler

Command/response scheduler between the single `generic_apb_io` conduit (`data_out`/`strobe`/`data_in`) and up to 4 FPGA-side client cores (DSP voices, parameter banks). It decodes each host write into a one-cycle write pulse to the addressed client. It arbitrates client responses round-robin into one held response register that the host reads through `data_in`. The host acknowledges each response with an explicit pop command.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of clients, 1..4.
- `PAYLOAD_W`, 24: payload width; fixed field layout assumes 24.

Ports:
- Reset is `reset_n`, asynchronous, active-low; the clock is `clock_clk`.
- `clock_clk` in 1: system clock, same domain as the APB IO block.
- `reset_n` in 1: async active-low reset.
- `io_data_out` in 32: command word from the APB IO `data_out`.
- `io_strobe` in 1: APB IO `strobe`; high after a host write, low after a host read setup.
- `io_data_in` out 32: response word to the APB IO `data_in`.
- `cl_wr_valid` out NUM_CLIENTS: one-hot, one-cycle write pulse per client.
- `cl_wr_data` out 24: payload, shared by all clients, valid with `cl_wr_valid`.
- `cl_rd_valid` in NUM_CLIENTS: client response pending.
- `cl_rd_data` in NUM_CLIENTS*24: client responses; client i occupies bits [24i+23:24i].
- `cl_rd_ready` out NUM_CLIENTS: one-hot accept; transfer occurs when valid&ready.
- `err_count` out 8: saturating count of dropped commands.

## Operation
- Command word fields: [31:28] id, [27:24] ignored, [23:0] payload.
- Command detect: a register `strobe_q` (reset 0) feeds `cmd_edge = io_strobe & ~strobe_q`. Exactly one command executes per 0->1 edge.
  - Host protocol: a read must occur between commands. Consecutive writes without a read produce no new edge, and only the first write executes.
- id < NUM_CLIENTS: `cl_wr_valid[id]` pulses for 1 cycle and `cl_wr_data = io_data_out[23:0]`.
- id = 0xF (POP): clears the response register (see FSM). A POP while EMPTY is a no-op and is not an error.
- Any other id: the command is dropped and `err_count` increments, saturating at 255.
- Response FSM:
  - EMPTY: `io_data_in[31]=0`. If any `cl_rd_valid` is set, grant the first valid client searching from `(last_grant+1) mod NUM_CLIENTS` upward with wrap. Assert `cl_rd_ready[g]` combinationally in the same cycle. On that clock edge, capture `{1'b1, 3'b000, 4'(g), cl_rd_data[g]}` into `io_data_in`, set `last_grant=g`, and go to FULL.
  - FULL: hold `io_data_in` unchanged and keep all `cl_rd_ready=0`. On a POP, clear bit 31 (other bits keep their values) and go to EMPTY.
- In EMPTY with no valid client, all ready signals stay 0 and `last_grant` is unchanged.
- Reset values:
  - `io_data_in=0`, `cl_wr_valid=0`, `cl_wr_data=0`, `err_count=0`.
  - State EMPTY; `last_grant=NUM_CLIENTS-1`, so client 0 has first priority.
- Reset asserted mid-operation: a held response is discarded and not re-requested. Clients must tolerate loss of an unacknowledged transfer only if valid&ready had already occurred.

## Timing
- Command latency: edge detected in cycle t, `cl_wr_valid` registered high in cycle t+1 only.
- POP latency: detected in cycle t, EMPTY in cycle t+1. The earliest next capture is the edge ending cycle t+1, so there is at least one dead cycle between responses.
- Capture: `cl_rd_ready` is combinational from state, `last_grant` and `cl_rd_valid`. Data is registered on the same edge as the handshake.
- `io_data_in` changes only on capture or POP. It is stable across the whole host read.
- A client write and a response capture in the same cycle are independent and both occur.
- The single-client case (NUM_CLIENTS=1) has no arbitration; the grant is always client 0.

## Test plan
- Reset, then strobe 0->1 with data_out=0x2000_0ABC → `cl_wr_valid=0b0100` for exactly 1 cycle, `cl_wr_data=0x000ABC`, no other pulses.
- Two writes with no intervening strobe fall → only the first executes. Write id=0x7 with NUM_CLIENTS=4 → no pulse, `err_count=1`. 300 bad commands → `err_count=255`.
- Clients 0 and 2 both valid from reset → client 0 is captured, `io_data_in=0x8000_0000|payload0`. After a POP, client 2 is captured with `io_data_in[27:24]=2`.
- All 4 clients held valid, 8 POP cycles → grant order 0,1,2,3,0,1,2,3; each `cl_rd_ready` lasts one cycle.
- While FULL, client 1 valid for 100 cycles → `cl_rd_ready` stays 0 and `io_data_in` is unchanged. POP in EMPTY → no state change, `err_count` unchanged.
- Assert reset_n low while FULL and during a `cl_wr_valid` pulse → all outputs are 0 immediately, and after release client 0 has priority.
